display_scan_ctrl: RTL and testbench



---
 rtl/display_scan_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_display_scan_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: time-multiplexed seven-segment scanner.
// Each digit slot has an all-anodes-off guard interval followed by a drive
// interval. The digit nibble and letter flag go out to an external
// combinational decoder, and its segment pattern is registered on the way back.
// Inputs are captured once per frame, so a frame always shows one consistent
// set of values.
module display_scan_ctrl #(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD_CYC   = 4
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    en_i,
  input  logic [4*NUM_DIGITS-1:0] data_i,
  input  logic [NUM_DIGITS-1:0]   ltr_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  output logic [3:0]              dec_data_o,
  output logic                    dec_ltr_o,
  input  logic [7:0]              seg_i,
  output logic [NUM_DIGITS-1:0]   an_o,
  output logic [7:0]              seg_o,
  output logic [2:0]              digit_o,
  output logic                    frame_o
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
  localparam logic [CNT_W-1:0] SLOT_LAST  = CNT_W'(REFRESH_DIV - 1);
  localparam logic [2:0]       DIGIT_LAST = 3'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GUARD = 2'd1,
    ST_DRIVE = 2'd2
  } state_t;

  state_t                  state, state_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic [2:0]              digit, digit_nxt;
  logic                    snap_take;

  logic [4*NUM_DIGITS-1:0] snap_data;
  logic [NUM_DIGITS-1:0]   snap_ltr;
  logic [NUM_DIGITS-1:0]   snap_dp;
  logic [NUM_DIGITS-1:0]   snap_blank;

  logic                    cur_dp;
  logic                    cur_blank;
  logic [NUM_DIGITS-1:0]   cur_onehot;
  logic [NUM_DIGITS-1:0]   an_nxt;
  logic [7:0]              seg_nxt;

  // The decoder's own dp bit is deliberately dropped; dp comes from dp_i.
  logic unused_seg_dp;
  assign unused_seg_dp = seg_i[7];

  assign digit_o = digit;

  // Select the current digit's snapshot fields (decoder feed plus dp/blank/anode).
  always_comb begin
    dec_data_o = '0;
    dec_ltr_o  = 1'b0;
    cur_dp     = 1'b0;
    cur_blank  = 1'b0;
    cur_onehot = '0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit == 3'(k)) begin
        dec_data_o    = snap_data[4*k +: 4];
        dec_ltr_o     = snap_ltr[k];
        cur_dp        = snap_dp[k];
        cur_blank     = snap_blank[k];
        cur_onehot[k] = 1'b1;
      end
    end
  end

  // State register: FSM state, slot counter and digit index.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      cnt   <= '0;
      digit <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      digit <= digit_nxt;
    end
  end

  // Next-state logic: guard then drive per slot, snapshot at each frame start.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    digit_nxt = digit;
    snap_take = 1'b0;
    if (!en_i) begin
      state_nxt = ST_IDLE;
      cnt_nxt   = '0;
      digit_nxt = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state_nxt = ST_GUARD;
          cnt_nxt   = '0;
          digit_nxt = '0;
          snap_take = 1'b1;
        end
        ST_GUARD: begin
          cnt_nxt = cnt + 1'b1;
          if (cnt == GUARD_LAST) begin
            state_nxt = ST_DRIVE;
          end
        end
        ST_DRIVE: begin
          if (cnt == SLOT_LAST) begin
            cnt_nxt   = '0;
            state_nxt = ST_GUARD;
            if (digit == DIGIT_LAST) begin
              digit_nxt = '0;
              snap_take = 1'b1;
            end else begin
              digit_nxt = digit + 3'd1;
            end
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          cnt_nxt   = '0;
          digit_nxt = '0;
        end
      endcase
    end
  end

  // Output logic: next anode/segment values, decoded from the upcoming state so
  // the pins are registered and glitch-free. Entering DRIVE never changes the
  // digit or the snapshot, so the current-digit selects are valid for it.
  always_comb begin
    an_nxt  = '1;
    seg_nxt = {~cur_dp, seg_i[6:0]};
    if ((state_nxt == ST_DRIVE) && !cur_blank) begin
      an_nxt = ~cur_onehot;
    end
    if (state_nxt == ST_IDLE) begin
      seg_nxt = 8'hFF;
    end
  end

  // Frame snapshot of all per-digit inputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      snap_data  <= '0;
      snap_ltr   <= '0;
      snap_dp    <= '0;
      snap_blank <= '0;
    end else if (snap_take) begin
      snap_data  <= data_i;
      snap_ltr   <= ltr_i;
      snap_dp    <= dp_i;
      snap_blank <= blank_i;
    end
  end

  // Output registers for the display pins and the frame pulse.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      an_o    <= '1;
      seg_o   <= 8'hFF;
      frame_o <= 1'b0;
    end else begin
      an_o    <= an_nxt;
      seg_o   <= seg_nxt;
      frame_o <= snap_take;
    end
  end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Testbench for display_scan_ctrl (4 digits, 8-cycle slots, 2-cycle guard).
// A behavioural decoder model feeds seg_i. Per-slot expectations are queued
// whenever inputs are set for a snapshot and are popped at each slot while the
// frame is checked cycle by cycle.
module tb_display_scan_ctrl;

  localparam int ND = 4;
  localparam int RD = 8;
  localparam int GC = 2;
  localparam int W  = 20;  // {digit[2:0], ltr, nibble[3:0], an[3:0], seg[7:0]}

  // Clock / reset block
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        en = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  ltr = '0;
  logic [3:0]  dp = '0;
  logic [3:0]  blank = '0;
  logic [3:0]  dec_data;
  logic        dec_ltr;
  logic [7:0]  seg_in;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic [2:0]  digit;
  logic        frame;

  int checks = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  display_scan_ctrl #(
    .NUM_DIGITS (ND),
    .REFRESH_DIV(RD),
    .GUARD_CYC  (GC)
  ) dut (
    .clk_i     (clk),
    .rst_i     (rst),
    .en_i      (en),
    .data_i    (data),
    .ltr_i     (ltr),
    .dp_i      (dp),
    .blank_i   (blank),
    .dec_data_o(dec_data),
    .dec_ltr_o (dec_ltr),
    .seg_i     (seg_in),
    .an_o      (an),
    .seg_o     (seg),
    .digit_o   (digit),
    .frame_o   (frame)
  );

  // Decoder model: active-low gfedcba; bit 7 always 0 so a DUT that forwarded
  // it instead of dp_i would show up.
  function automatic logic [7:0] dec_model(input logic [3:0] d, input logic l);
    logic [6:0] p;
    p = 7'h00;
    if (!l) begin
      case (d)
        4'h0: p = 7'h3F; 4'h1: p = 7'h06; 4'h2: p = 7'h5B; 4'h3: p = 7'h4F;
        4'h4: p = 7'h66; 4'h5: p = 7'h6D; 4'h6: p = 7'h7D; 4'h7: p = 7'h07;
        4'h8: p = 7'h7F; 4'h9: p = 7'h6F; 4'hA: p = 7'h77; 4'hB: p = 7'h7C;
        4'hC: p = 7'h39; 4'hD: p = 7'h5E; 4'hE: p = 7'h79; default: p = 7'h71;
      endcase
    end else begin
      case (d)
        4'h0: p = 7'h77; 4'h1: p = 7'h7C; 4'h2: p = 7'h39; 4'h3: p = 7'h5E;
        4'h4: p = 7'h79; 4'h5: p = 7'h71; 4'h6: p = 7'h3D; 4'h7: p = 7'h76;
        4'h8: p = 7'h30; 4'h9: p = 7'h1E; 4'hA: p = 7'h38; 4'hB: p = 7'h54;
        4'hC: p = 7'h5C; 4'hD: p = 7'h73; 4'hE: p = 7'h50; default: p = 7'h3E;
      endcase
    end
    return {1'b0, ~p};
  endfunction

  assign seg_in = dec_model(dec_data, dec_ltr);

  // Anode safety monitor: at most one anode low, never a direct low-to-low move.
  logic [3:0] prev_an = 4'hF;
  always @(negedge clk) begin
    checks++;
    if ($countones(~an) > 1) begin
      failures++;
      $display("FAIL an_multi got=%b exp=at_most_one_low", an);
    end
    checks++;
    if (($countones(~an) == 1) && ($countones(~prev_an) == 1) && (an != prev_an)) begin
      failures++;
      $display("FAIL an_ghost got=%b prev=%b exp=guard_between", an, prev_an);
    end
    prev_an = an;
  end

  // Driver: queue the expected per-slot display for the current input values.
  task automatic push_frame();
    logic [7:0] pat;
    logic [3:0] nib;
    logic [3:0] an_e;
    for (int d = 0; d < ND; d++) begin
      nib  = data[4*d +: 4];
      pat  = dec_model(nib, ltr[d]);
      an_e = blank[d] ? 4'hF : ~(4'b0001 << d);
      exp_q.push_back({3'(d), ltr[d], nib, an_e, ~dp[d], pat[6:0]});
    end
  endtask

  // Scoreboard: called at the frame_o cycle, checks every cycle of one frame and
  // returns at the first cycle of the next frame. Optionally changes data_i at
  // mid_t and queues the expectation for the following frame.
  task automatic check_frame(input int mid_t, input logic [15:0] mid_data);
    logic [W-1:0] e;
    logic [3:0]   exp_an;
    logic         exp_frame;
    int           pos;
    e = '0;
    for (int t = 0; t < ND*RD; t++) begin
      if (t > 0) @(negedge clk);
      pos = t % RD;
      if (pos == 0) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL sb_empty t=%0d got=0 exp=entry", t);
        end else begin
          e = exp_q.pop_front();
        end
      end
      exp_frame = (t == 0) ? 1'b1 : 1'b0;
      checks++;
      if (frame !== exp_frame) begin
        failures++;
        $display("FAIL frame t=%0d got=%b exp=%b", t, frame, exp_frame);
      end
      checks++;
      if (digit !== e[19:17]) begin
        failures++;
        $display("FAIL digit t=%0d got=%0d exp=%0d", t, digit, e[19:17]);
      end
      checks++;
      if ((dec_ltr !== e[16]) || (dec_data !== e[15:12])) begin
        failures++;
        $display("FAIL dec t=%0d got=%b/%h exp=%b/%h", t, dec_ltr, dec_data, e[16], e[15:12]);
      end
      exp_an = (pos >= GC) ? e[11:8] : 4'hF;
      checks++;
      if (an !== exp_an) begin
        failures++;
        $display("FAIL an t=%0d got=%b exp=%b", t, an, exp_an);
      end
      if (pos >= 1) begin
        checks++;
        if (seg !== e[7:0]) begin
          failures++;
          $display("FAIL seg t=%0d got=%h exp=%h", t, seg, e[7:0]);
        end
      end
      if (t == mid_t) begin
        data = mid_data;
        push_frame();
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; data = 16'h4321; ltr = 4'b0000; dp = 4'b0100; blank = 4'b0000;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ((an !== 4'hF) || (seg !== 8'hFF) || (frame !== 1'b0) || (digit !== 3'd0)
          || (dec_data !== 4'h0) || (dec_ltr !== 1'b0)) begin
        failures++;
        $display("FAIL reset_vals got=%b/%h/%b/%0d/%h/%b exp=1111/ff/0/0/0/0",
                 an, seg, frame, digit, dec_data, dec_ltr);
      end
    end
    push_frame();
    rst = 1'b0;
    @(negedge clk);
    check_frame(-1, 16'h0);
  endtask

  task automatic test_dp_scan();
    push_frame();
    check_frame(-1, 16'h0);
  endtask

  task automatic test_coherency();
    push_frame();
    check_frame(RD + 2, 16'hAAAA);
    check_frame(-1, 16'h0);
  endtask

  task automatic test_blank();
    push_frame();
    blank = 4'b0010; ltr = 4'b1001; data = 16'h5E0C; dp = 4'b1010;
    push_frame();
    check_frame(-1, 16'h0);
    push_frame();
    check_frame(-1, 16'h0);
    check_frame(-1, 16'h0);
  endtask

  task automatic test_en_drop();
    repeat (2*RD + 4) @(negedge clk);
    checks++;
    if (an !== 4'b1011) begin
      failures++;
      $display("FAIL en_drop_pre got=%b exp=1011", an);
    end
    en = 1'b0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ((an !== 4'hF) || (seg !== 8'hFF) || (digit !== 3'd0) || (frame !== 1'b0)) begin
        failures++;
        $display("FAIL en_drop got=%b/%h/%0d/%b exp=1111/ff/0/0", an, seg, digit, frame);
      end
    end
    en = 1'b1;
    push_frame();
    @(negedge clk);
    check_frame(-1, 16'h0);
  endtask

  task automatic test_random();
    push_frame();
    for (int i = 0; i < 3; i++) begin
      data  = 16'($urandom_range(0, 65535));
      ltr   = 4'($urandom_range(0, 15));
      dp    = 4'($urandom_range(0, 15));
      blank = 4'($urandom_range(0, 15));
      push_frame();
      check_frame(-1, 16'h0);
    end
  endtask

  task automatic test_reset_mid();
    data = 16'h7777; ltr = 4'hF; dp = 4'h0; blank = 4'h0;
    push_frame();
    check_frame(-1, 16'h0);
    repeat (RD + 5) @(negedge clk);
    checks++;
    if (dec_data !== 4'h7) begin
      failures++;
      $display("FAIL pre_reset_dec got=%h exp=7", dec_data);
    end
    rst = 1'b1;
    exp_q.delete();
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ((an !== 4'hF) || (seg !== 8'hFF) || (frame !== 1'b0) || (digit !== 3'd0)
          || (dec_data !== 4'h0) || (dec_ltr !== 1'b0)) begin
        failures++;
        $display("FAIL reset_mid got=%b/%h/%b/%0d/%h/%b exp=1111/ff/0/0/0/0",
                 an, seg, frame, digit, dec_data, dec_ltr);
      end
    end
    rst = 1'b0; data = 16'h9876; ltr = 4'b0100; dp = 4'b0001;
    push_frame();
    @(negedge clk);
    check_frame(-1, 16'h0);
  endtask

  initial begin
    test_reset();
    test_dp_scan();
    test_coherency();
    test_blank();
    test_en_drop();
    test_random();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
